// File: rtl/mcu_run_sequencer.sv
// mcu_run_sequencer
//   Run controller and port monitor for the MCU51 core. It sequences
//   WARM -> SRST -> RUN -> DONE, drives the core's active-high soft reset and,
//   while in RUN, timestamps every change on the monitored ports into a
//   show-ahead event FIFO that is read over valid/ready.
//
// Ports
//   CLK        clock, rising edge
//   resetn     synchronous reset, active low
//   ports_in   monitored ports, port k = ports_in[k*PW +: PW]
//   restart    one-cycle pulse, honoured only in DONE
//   core_reset soft reset to the core, active high (high exactly in SRST)
//   done       high in DONE
//   evt_valid  FIFO head valid
//   evt_ready  consumer accepts the head
//   evt_mask   ports that changed in the head event
//   evt_data   full port snapshot taken with the change
//   evt_time   RUN-cycle index of the change, saturating
//   overflow   sticky: at least one event was dropped
//   drop_cnt   number of dropped events, saturating at 255
module mcu_run_sequencer #(
  parameter int unsigned NPORTS     = 4,
  parameter int unsigned PW         = 8,
  parameter int unsigned HOLD_CYC   = 500,
  parameter int unsigned RST_CYC    = 100,
  parameter int unsigned RUN_CYC    = 2700,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TW         = 16
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic [NPORTS*PW-1:0]   ports_in,
  input  logic                   restart,
  output logic                   core_reset,
  output logic                   done,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [NPORTS-1:0]      evt_mask,
  output logic [NPORTS*PW-1:0]   evt_data,
  output logic [TW-1:0]          evt_time,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned DW = NPORTS * PW;
  localparam int unsigned EW = NPORTS + DW + TW;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StWarm = 2'd0;
  localparam logic [1:0] StSrst = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Largest representable timestamp; the run counter clamps to it.
  localparam logic [31:0] TMax = 32'((64'd1 << TW) - 64'd1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [DW-1:0] prev_q;

  logic [AW:0]   wptr_q, rptr_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] last_q;
  logic          overflow_q;
  logic [7:0]    drop_cnt_q;

  logic [NPORTS-1:0] mask;
  logic [TW-1:0]     t_sat;
  logic              push_req, pop, push_ok, drop;
  logic              full, empty;
  logic [EW-1:0]     head;

  // ---------------------------------------------------------------------------
  // Sequencer FSM; the single counter restarts on every state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    unique case (state_q)
      StWarm: begin
        if (cnt_q == HOLD_CYC - 1) begin
          state_d = StSrst;
          cnt_d   = '0;
        end
      end
      StSrst: begin
        if (cnt_q == RST_CYC - 1) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (cnt_q == RUN_CYC - 1) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        cnt_d = cnt_q;
        if (restart) begin
          state_d = StSrst;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWarm;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= StWarm;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_reset = (state_q == StSrst);
  assign done       = (state_q == StDone);

  // ---------------------------------------------------------------------------
  // Change detection. prev_q samples every edge, so the first RUN cycle
  // compares against the last SRST sample and RUN entry raises no event.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    prev_q <= ports_in;
  end

  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      mask[k] = (ports_in[k*PW +: PW] != prev_q[k*PW +: PW]);
    end
  end

  assign t_sat    = (cnt_q > TMax) ? TMax[TW-1:0] : cnt_q[TW-1:0];
  assign push_req = (state_q == StRun) && (mask != '0);

  // ---------------------------------------------------------------------------
  // Event FIFO: extra pointer MSB distinguishes full from empty.
  // ---------------------------------------------------------------------------
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && evt_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= {mask, ports_in, t_sat};
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
      // Remember the presented head so outputs hold once the FIFO empties.
      if (!empty) begin
        last_q <= head;
      end
    end
  end

  always_comb begin
    head = mem_q[rptr_q[AW-1:0]];
    if (empty) begin
      head = last_q;
    end
  end

  assign evt_valid = !empty;
  assign evt_mask  = head[EW-1 -: NPORTS];
  assign evt_data  = head[TW +: DW];
  assign evt_time  = head[TW-1:0];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
